// File: rtl/clavier_ps2.sv
// PS/2 keyboard receiver: filters the PS/2 clock, deframes 11-bit words and
// decodes arrow / keypad make codes into one-cycle plus / moins pulses.
module clavier_ps2 #(
  parameter int unsigned FILTRE  = 8,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic       plus,
  output logic       moins,
  output logic [7:0] octet,
  output logic       octetValide,
  output logic       erreur
);

  localparam int unsigned FW = $clog2(FILTRE + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic {REPOS, RECOIT} etat_t;

  etat_t        etat, etat_n;
  logic         clk_s1, clk_s2, dat_s1, dat_s2;
  logic         filt;
  logic [FW-1:0] fcnt;
  logic         fe;
  logic [10:0]  sr, sr_n;
  logic [10:0]  trame;
  logic [3:0]   nb, nb_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [7:0]   octet_n;
  logic         ov_n, err_n;
  logic         etendu, relache;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2Clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2Data;
      dat_s2 <= dat_s1;
    end
  end

  // The filtered level follows the synchronized clock only after FILTRE
  // consecutive cycles of disagreement; fe fires on the cycle it drops to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (clk_s2 == filt) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILTRE - 1)) begin
      filt <= clk_s2;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign fe    = filt && !clk_s2 && (fcnt == FW'(FILTRE - 1));
  // Bits enter at the top so the first (start) bit ends up in sr[0].
  assign trame = {dat_s2, sr[10:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      etat        <= REPOS;
      sr          <= '0;
      nb          <= '0;
      tcnt        <= '0;
      octet       <= '0;
      octetValide <= 1'b0;
      erreur      <= 1'b0;
    end else begin
      etat        <= etat_n;
      sr          <= sr_n;
      nb          <= nb_n;
      tcnt        <= tcnt_n;
      octet       <= octet_n;
      octetValide <= ov_n;
      erreur      <= err_n;
    end
  end

  always_comb begin
    etat_n  = etat;
    sr_n    = sr;
    nb_n    = nb;
    tcnt_n  = tcnt;
    octet_n = octet;
    ov_n    = 1'b0;
    err_n   = 1'b0;
    case (etat)
      REPOS: begin
        tcnt_n = '0;
        if (fe) begin
          sr_n   = trame;
          nb_n   = 4'd1;
          etat_n = RECOIT;
        end
      end
      RECOIT: begin
        if (fe) begin
          sr_n   = trame;
          tcnt_n = '0;
          if (nb == 4'd10) begin
            if (!trame[0] && (^trame[9:1]) && trame[10]) begin
              octet_n = trame[8:1];
              ov_n    = 1'b1;
            end else begin
              err_n = 1'b1;
            end
            nb_n   = '0;
            etat_n = REPOS;
          end else begin
            nb_n = nb + 4'd1;
          end
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          err_n  = 1'b1;
          sr_n   = '0;
          nb_n   = '0;
          tcnt_n = '0;
          etat_n = REPOS;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      default: etat_n = REPOS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      etendu  <= 1'b0;
      relache <= 1'b0;
      plus    <= 1'b0;
      moins   <= 1'b0;
    end else begin
      plus  <= 1'b0;
      moins <= 1'b0;
      if (erreur) begin
        etendu  <= 1'b0;
        relache <= 1'b0;
      end else if (octetValide) begin
        if (octet == 8'hE0) begin
          etendu <= 1'b1;
        end else if (octet == 8'hF0) begin
          relache <= 1'b1;
        end else begin
          if (!relache) begin
            plus  <= (etendu && octet == 8'h74) || (!etendu && octet == 8'h79);
            moins <= (etendu && octet == 8'h6B) || (!etendu && octet == 8'h7B);
          end
          etendu  <= 1'b0;
          relache <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clavier_ps2.sv
// Scoreboard bench for clavier_ps2: stimulus queues expected events, a
// negedge monitor pops and compares every output pulse.
module tb_clavier_ps2;

  localparam int unsigned FILTRE  = 8;
  localparam int unsigned TIMEOUT = 2000;
  localparam int HALF = 40;
  localparam int GAP  = 100;
  localparam int K_OV = 0, K_ERR = 1, K_PLUS = 2, K_MOINS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic       plus, moins, octetValide, erreur;
  logic [7:0] octet;

  typedef struct {
    int         kind;
    logic [7:0] b;
  } ev_t;

  ev_t q[$];
  int  compared = 0;
  int  mismatched = 0;
  int  cyc = 0;
  int  last_ov = -100;

  clavier_ps2 #(.FILTRE(FILTRE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ps2Clk(ps2Clk), .ps2Data(ps2Data),
    .plus(plus), .moins(moins), .octet(octet),
    .octetValide(octetValide), .erreur(erreur)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_ev(input int k, input logic [7:0] b);
    ev_t e;
    e.kind = k;
    e.b    = b;
    q.push_back(e);
  endtask

  task automatic check_ev(input int k, input logic [7:0] b);
    ev_t e;
    compared++;
    if (q.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_event: got kind %0d byte %02h, expected none", k, b);
    end else begin
      e = q.pop_front();
      if (e.kind != k || (k == K_OV && e.b != b)) begin
        mismatched++;
        $display("FAIL event_order: got kind %0d byte %02h, expected kind %0d byte %02h",
                 k, b, e.kind, e.b);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (plus && moins) begin
        compared++;
        mismatched++;
        $display("FAIL plus_moins_exclusive: got both 1, expected at most one");
      end
      if (octetValide) check_ev(K_OV, octet);
      if (erreur) check_ev(K_ERR, 8'h00);
      if (plus || moins) begin
        check_ev(plus ? K_PLUS : K_MOINS, 8'h00);
        compared++;
        if (cyc - last_ov != 1) begin
          mismatched++;
          $display("FAIL cmd_latency: got %0d cycles after octetValide, expected 1", cyc - last_ov);
        end
      end
      if (octetValide) last_ov = cyc;
    end
  end

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    if (glitch) begin
      wait_cyc(20);
      ps2Clk = 1'b0;
      wait_cyc(3);
      ps2Clk = 1'b1;
    end
    ps2Data = b;
    wait_cyc(HALF);
    ps2Clk = 1'b0;
    wait_cyc(HALF);
    ps2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip_par,
                            input int nbits, input logic glitch);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ flip_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], glitch);
    ps2Data = 1'b1;
    wait_cyc(GAP);
  endtask

  task automatic check_quiet(input string name, input logic [7:0] oct_exp);
    compared++;
    if ({plus, moins, octetValide, erreur} != 4'b0 || octet !== oct_exp) begin
      mismatched++;
      $display("FAIL %s: got plus=%b moins=%b ov=%b err=%b octet=%02h, expected 0 0 0 0 %02h",
               name, plus, moins, octetValide, erreur, octet, oct_exp);
    end
  endtask

  initial begin
    wait_cyc(5);
    check_quiet("reset_state", 8'h00);
    reset = 1'b0;
    wait_cyc(20);
    check_quiet("idle_after_reset", 8'h00);

    // E0 74 -> right arrow
    push_ev(K_OV, 8'hE0);
    send_frame(8'hE0, 1'b0, 11, 1'b0);
    push_ev(K_OV, 8'h74);
    push_ev(K_PLUS, 8'h00);
    send_frame(8'h74, 1'b0, 11, 1'b0);

    // 7B make, then F0 7B break, then bare 74 and 79 prove both flags cleared
    push_ev(K_OV, 8'h7B);
    push_ev(K_MOINS, 8'h00);
    send_frame(8'h7B, 1'b0, 11, 1'b0);
    push_ev(K_OV, 8'hF0);
    send_frame(8'hF0, 1'b0, 11, 1'b0);
    push_ev(K_OV, 8'h7B);
    send_frame(8'h7B, 1'b0, 11, 1'b0);
    push_ev(K_OV, 8'h74);
    send_frame(8'h74, 1'b0, 11, 1'b0);
    push_ev(K_OV, 8'h79);
    push_ev(K_PLUS, 8'h00);
    send_frame(8'h79, 1'b0, 11, 1'b0);

    // 6B with bad parity, then E0 6B
    push_ev(K_ERR, 8'h00);
    send_frame(8'h6B, 1'b1, 11, 1'b0);
    check_quiet("octet_kept_after_parity_err", 8'h79);
    push_ev(K_OV, 8'hE0);
    send_frame(8'hE0, 1'b0, 11, 1'b0);
    push_ev(K_OV, 8'h6B);
    push_ev(K_MOINS, 8'h00);
    send_frame(8'h6B, 1'b0, 11, 1'b0);

    // 5 bits then silence -> timeout, then 79
    push_ev(K_ERR, 8'h00);
    send_frame(8'h55, 1'b0, 5, 1'b0);
    wait_cyc(TIMEOUT + 10);
    check_quiet("octet_kept_after_timeout", 8'h6B);
    push_ev(K_OV, 8'h79);
    push_ev(K_PLUS, 8'h00);
    send_frame(8'h79, 1'b0, 11, 1'b0);

    // 3-cycle glitches between bits
    push_ev(K_OV, 8'h7B);
    push_ev(K_MOINS, 8'h00);
    send_frame(8'h7B, 1'b0, 11, 1'b1);

    // reset after 6 bits, then a bare 74
    send_frame(8'hE0, 1'b0, 6, 1'b0);
    reset = 1'b1;
    wait_cyc(1);
    check_quiet("outputs_in_reset", 8'h00);
    reset = 1'b0;
    wait_cyc(1);
    check_quiet("outputs_after_reset", 8'h00);
    push_ev(K_OV, 8'h74);
    send_frame(8'h74, 1'b0, 11, 1'b0);

    wait_cyc(50);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL missing_events: got %0d expected events never seen, expected 0", q.size());
    end
    compared++;
    if (octet !== 8'h74) begin
      mismatched++;
      $display("FAIL final_octet: got %02h, expected 74", octet);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
